load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface. Accepts load/store requests from the execute/memory pipeline stage and drives the word-addressed, single-port data memory: write asserted and committed at a clock edge, combinational read. Supports byte, halfword and word accesses. Sub-word stores use read-modify-write. Loads are returned sign- or zero-extended. Misaligned and out-of-range accesses are rejected without touching memory.

## Interface
- WIDTH, 32, data and address width; fixed at 32 for byte-lane logic
- MEM_DEPTH, 256, number of memory words; legal word index range is 0..MEM_DEPTH-1

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or out of range
- resp_rdata  out  WIDTH  load result, valid with resp_valid; 0 for stores and errors
- mem_write_read  out  1  memory write enable (1 = write)
- mem_address  out  WIDTH  word index = req_addr[31:2]; upper bits zero
- mem_write_data  out  WIDTH  merged word to write
- mem_read_data  in  WIDTH  combinational memory read data

## Operation
- FSM states: IDLE, RD, WR, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch we, size, unsigned, addr and wdata.
  - Error check: size==11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= MEM_DEPTH. Any error → RESP with err=1.
  - Otherwise: load or sub-word store → RD; word store → WR.
- **RD**
  - mem_write_read=0.
  - Capture mem_read_data into the word buffer.
  - Load → RESP; store → WR.
- **WR**
  - mem_write_read=1 for exactly this cycle.
  - Word store: mem_write_data = wdata.
  - Sub-word store: mem_write_data = buffer with selected lanes replaced.
  - Lanes are little-endian: byte k = bits 8k+7:8k, selected by addr[1:0]. Half lane is selected by addr[1].
  - Next state → RESP.
- **RESP**
  - resp_valid=1 for one cycle.
  - Load: resp_rdata = extracted lane, extended to 32 bits.
  - Next state → IDLE.
- mem_write_read is 0 in every state except WR.
- mem_address and mem_write_data come from registers and hold their last value outside active states.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_write_read=0, mem_address=0, mem_write_data=0, buffer=0.
- Reset takes effect asynchronously at any time. If reset is asserted during WR, mem_write_read drops immediately, so the pending write does not commit. No response is issued for an aborted request.

## Timing
- Request accepted at edge of cycle N.
- resp_valid timing:
  - error: cycle N+1
  - word store: cycle N+2
  - load: cycle N+2
  - sub-word store: cycle N+3
- Store data is in memory after the edge that ends the WR cycle. A load accepted in the RESP cycle's following IDLE sees it.
- Back-to-back: the next request is accepted no earlier than the IDLE cycle after RESP. Held req_valid is not consumed while req_ready=0.

## Structure
- Shared package `lsu_pkg` holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - WIDTH-derived constants
- Sub-module `lsu_align` (purely combinational) holds:
  - store merge: buffer, wdata, size, offset → word
  - load extract/extend: word, size, offset, unsigned → rdata
- The top level holds the FSM and registers.

## Test plan
1. Word store 0xDEADBEEF @0x10:
   - mem_write_read high one cycle with mem_address=4.
   - resp_valid at N+2 with err=0.
   - Word load @0x10 returns 0xDEADBEEF at N+2.
2. With word 4 = 0xDEADBEEF, byte store 0xA5 @0x13:
   - RD then WR; memory word becomes 0xA5ADBEEF.
   - Signed byte load @0x13 → 0xFFFFFFA5; unsigned → 0x000000A5.
3. Half store 0x8001 @0x10 onto 0xA5ADBEEF:
   - Word becomes 0xA5AD8001.
   - Signed half load @0x10 → 0xFFFF8001; unsigned half @0x12 → 0x0000A5AD.
4. Error cases: half load @0x11, word store @0x12, size 11, word store @0x400:
   - Each gives resp_err=1 at N+1.
   - mem_write_read never asserts; memory is unchanged.
5. Reset asserted mid-WR of byte store @0x13:
   - mem_write_read falls immediately; word 4 is unchanged.
   - After release: req_ready=1 and resp_valid stays 0.
6. req_valid held across two queued requests (store then load, same address):
   - Second request is accepted only in the IDLE cycle after the first RESP.
   - Load returns the stored value.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and data-path constants.
package lsu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned OFF_W  = 2;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RESP
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: merges store data into a read-back word and extracts and
// extends load lanes. Lanes are little-endian, picked by the low address bits.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0]  i_buf,
   input  logic [XLEN-1:0]  i_wdata,
   input  logic [XLEN-1:0]  i_word,
   input  logic [1:0]       i_size,
   input  logic [OFF_W-1:0] i_off,
   input  logic             i_unsigned,
   output logic [XLEN-1:0]  o_merged,
   output logic [XLEN-1:0]  o_rdata
);

   logic [4:0]        w_bsh;
   logic [4:0]        w_hsh;
   logic [BYTE_W-1:0] w_byte;
   logic [HALF_W-1:0] w_half;

   assign w_bsh  = {i_off, 3'b000};
   assign w_hsh  = {i_off[1], 4'b0000};
   assign w_byte = i_word[w_bsh +: BYTE_W];
   assign w_half = i_word[w_hsh +: HALF_W];

   always_comb begin
      o_merged = i_buf;
      case (i_size)
         SZ_BYTE: o_merged[w_bsh +: BYTE_W] = i_wdata[BYTE_W-1:0];
         SZ_HALF: o_merged[w_hsh +: HALF_W] = i_wdata[HALF_W-1:0];
         default: o_merged = i_wdata;
      endcase
   end

   always_comb begin
      o_rdata = i_word;
      case (i_size)
         SZ_BYTE: o_rdata = {{(XLEN-BYTE_W){~i_unsigned & w_byte[BYTE_W-1]}}, w_byte};
         SZ_HALF: o_rdata = {{(XLEN-HALF_W){~i_unsigned & w_half[HALF_W-1]}}, w_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: a four-state FSM handling byte/half/word loads and
// stores, with read-modify-write for sub-word stores and early error rejection.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic             resp_err,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             mem_write_read,
   output logic [WIDTH-1:0] mem_address,
   output logic [WIDTH-1:0] mem_write_data,
   input  logic [WIDTH-1:0] mem_read_data
);

   lsu_state_t       r_state;
   lsu_state_t       w_next;
   logic             r_we;
   logic [1:0]       r_size;
   logic             r_uns;
   logic [OFF_W-1:0] r_off;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_buf;
   logic             r_err;
   logic [WIDTH-1:0] r_mem_addr;
   logic [WIDTH-1:0] r_mem_wdata;
   logic             w_misalign;
   logic             w_range;
   logic             w_err;
   logic [WIDTH-1:0] w_merged;
   logic [WIDTH-1:0] w_rdata;

   assign w_misalign = (req_size == SZ_HALF && req_addr[0]) ||
                       (req_size == SZ_WORD && req_addr[OFF_W-1:0] != '0);
   assign w_range    = {2'b00, req_addr[WIDTH-1:OFF_W]} >= WIDTH'(MEM_DEPTH);
   assign w_err      = (req_size == SZ_BAD) || w_misalign || w_range;

   lsu_align u_align (
      .i_buf      (mem_read_data),
      .i_wdata    (r_wdata),
      .i_word     (r_buf),
      .i_size     (r_size),
      .i_off      (r_off),
      .i_unsigned (r_uns),
      .o_merged   (w_merged),
      .o_rdata    (w_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_err)                              w_next = S_RESP;
               else if (req_we && req_size == SZ_WORD) w_next = S_WR;
               else                                    w_next = S_RD;
            end
         end
         S_RD:    w_next = r_we ? S_WR : S_RESP;
         S_WR:    w_next = S_RESP;
         default: w_next = S_IDLE;
      endcase
   end

   // Write data is registered one state early so the WR cycle drives a stable word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we        <= 1'b0;
         r_size      <= SZ_BYTE;
         r_uns       <= 1'b0;
         r_off       <= '0;
         r_wdata     <= '0;
         r_buf       <= '0;
         r_err       <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_size  <= req_size;
                  r_uns   <= req_unsigned;
                  r_off   <= req_addr[OFF_W-1:0];
                  r_wdata <= req_wdata;
                  r_err   <= w_err;
                  if (!w_err) begin
                     r_mem_addr <= {2'b00, req_addr[WIDTH-1:OFF_W]};
                     if (req_we && req_size == SZ_WORD) r_mem_wdata <= req_wdata;
                  end
               end
            end
            S_RD: begin
               r_buf <= mem_read_data;
               if (r_we) r_mem_wdata <= w_merged;
            end
            default: ;
         endcase
      end
   end

   assign req_ready      = (r_state == S_IDLE);
   assign resp_valid     = (r_state == S_RESP);
   assign resp_err       = resp_valid && r_err;
   assign resp_rdata     = (resp_valid && !r_err && !r_we) ? w_rdata : '0;
   assign mem_write_read = (r_state == S_WR);
   assign mem_address    = r_mem_addr;
   assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: a transaction-level model of latency, lane arithmetic and
// memory contents, checked every cycle, plus directed literal expectations.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_write_read;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.WIDTH(32), .MEM_DEPTH(256)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_err       (resp_err),
      .resp_rdata     (resp_rdata),
      .mem_write_read (mem_write_read),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   // Data memory attached to the DUT
   logic [31:0] mem [0:255];
   always @(posedge clk) if (mem_write_read === 1'b1) mem[mem_address[7:0]] <= mem_write_data;
   assign mem_read_data = (mem_address < 32'd256) ? mem[mem_address[7:0]] : '0;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        err;
      logic        store;
      int unsigned lat;
      logic [7:0]  idx;
      logic [31:0] merge;
      logic [31:0] rd;
   } mtx_t;

   logic [31:0] gold [0:255];
   mtx_t        m_t;
   int unsigned m_k;
   logic        m_busy;

   function automatic mtx_t predict(input logic we, input logic [1:0] sz, input logic uns,
                                    input logic [31:0] a, input logic [31:0] wd);
      mtx_t        t;
      logic [31:0] old;
      int unsigned sh;
      int unsigned sh16;
      logic [31:0] v;
      t.err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a % 4 != 0) ||
                ((a / 4) >= 256);
      t.store = we;
      t.idx   = 8'((a / 4) % 256);
      t.merge = '0;
      t.rd    = '0;
      old     = gold[t.idx];
      sh      = (a % 4) * 8;
      sh16    = ((a % 4) / 2) * 16;
      if (t.err) begin
         t.lat = 1;
      end else if (we) begin
         t.lat = (sz == 2'd2) ? 2 : 3;
         if (sz == 2'd0)      t.merge = (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
         else if (sz == 2'd1) t.merge = (old & ~(32'hFFFF << sh16)) | ((wd & 32'hFFFF) << sh16);
         else                 t.merge = wd;
      end else begin
         t.lat = 2;
         if (sz == 2'd0) begin
            v = (old >> sh) & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFFFF00;
         end else if (sz == 2'd1) begin
            v = (old >> sh16) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF0000;
         end else begin
            v = old;
         end
         t.rd = v;
      end
      return t;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_k    <= 0;
      end else if (m_busy) begin
         if (m_t.store && !m_t.err && m_k == m_t.lat - 1) gold[m_t.idx] <= m_t.merge;
         if (m_k == m_t.lat) m_busy <= 1'b0;
         else                m_k    <= m_k + 1;
      end else if (req_valid) begin
         m_t    <= predict(req_we, req_size, req_unsigned, req_addr, req_wdata);
         m_k    <= 1;
         m_busy <= 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic        chk_en = 1'b0;
   int unsigned wr_cnt = 0;
   int unsigned resp_cnt = 0;
   logic [31:0] last_wr_addr = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_resp;
         logic exp_wr;
         exp_resp = m_busy && (m_k == m_t.lat);
         exp_wr   = m_busy && m_t.store && !m_t.err && (m_k == m_t.lat - 1);
         chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
         chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_resp});
         chk("mem_write_read", {31'b0, mem_write_read}, {31'b0, exp_wr});
         if (exp_wr) begin
            chk("mem_address", mem_address, {24'b0, m_t.idx});
            chk("mem_write_data", mem_write_data, m_t.merge);
         end
         if (exp_resp) begin
            chk("resp_err", {31'b0, resp_err}, {31'b0, m_t.err});
            chk("resp_rdata", resp_rdata, m_t.rd);
         end
         if (mem_write_read === 1'b1) begin
            wr_cnt++;
            last_wr_addr = mem_address;
         end
         if (resp_valid === 1'b1) resp_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic keep,
                       output int unsigned acc_cyc);
      logic        rdy;
      int unsigned n;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      n = 0;
      do begin
         rdy = req_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 20);
      chk("accept_timeout", {31'b0, rdy}, 32'd1);
      acc_cyc = cyc;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_resp(output logic [31:0] rd, output logic er, output int unsigned lat);
      rd  = '0;
      er  = 1'b0;
      lat = 0;
      for (int unsigned i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            rd  = resp_rdata;
            er  = resp_err;
            lat = i;
            break;
         end
      end
   endtask

   task automatic txn(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int unsigned elat,
                      input logic eerr, input logic [31:0] erd);
      int unsigned c;
      logic [31:0] rd;
      logic        er;
      int unsigned lat;
      send(we, sz, uns, a, wd, 1'b0, c);
      wait_resp(rd, er, lat);
      chk({nm, "_lat"}, lat, elat);
      chk({nm, "_err"}, {31'b0, er}, {31'b0, eerr});
      chk({nm, "_rdata"}, rd, erd);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned c1;
      int unsigned c2;
      int unsigned wr0;
      int unsigned rsp0;
      logic [31:0] rd;
      logic        er;
      int unsigned lat;

      for (int i = 0; i < 256; i++) begin
         mem[i]  = '0;
         gold[i] = '0;
      end
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_we", {31'b0, mem_write_read}, 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_wdata", mem_write_data, 32'd0);
      #1 reset = 1'b0;
      @(negedge clk); #1;

      // word store / load
      wr0 = wr_cnt;
      txn("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
      chk("sw_10_wr_cycles", wr_cnt - wr0, 32'd1);
      chk("sw_10_wr_addr", last_wr_addr, 32'd4);
      chk("mem4_word", mem[4], 32'hDEADBEEF);
      txn("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);

      // byte store via read-modify-write, signed/unsigned byte loads
      txn("sb_13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 3, 1'b0, 32'h0);
      chk("mem4_byte", mem[4], 32'hA5ADBEEF);
      txn("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFFA5);
      txn("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'h000000A5);
      txn("lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 1'b0, 32'h000000BE);

      // halfword store and loads
      txn("sh_10", 1'b1, 2'b01, 1'b0, 32'h10, 32'h00008001, 3, 1'b0, 32'h0);
      chk("mem4_half", mem[4], 32'hA5AD8001);
      txn("lh_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hFFFF8001);
      txn("lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'h0000A5AD);
      txn("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1'b0, 32'hFFFFA5AD);

      // error cases and the last legal word
      wr0 = wr_cnt;
      txn("err_lh_11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1, 1'b1, 32'h0);
      txn("err_sw_12", 1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, 1, 1'b1, 32'h0);
      txn("err_size3", 1'b1, 2'b11, 1'b0, 32'h10, 32'h22222222, 1, 1'b1, 32'h0);
      txn("err_sw_400", 1'b1, 2'b10, 1'b0, 32'h400, 32'h33333333, 1, 1'b1, 32'h0);
      chk("err_no_writes", wr_cnt - wr0, 32'd0);
      chk("mem4_after_err", mem[4], 32'hA5AD8001);
      txn("lw_3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 2, 1'b0, 32'h0);
      txn("sw_3fc", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, 2, 1'b0, 32'h0);
      chk("mem255", mem[255], 32'hCAFEF00D);

      // reset in the middle of the write cycle
      send(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000011, 1'b0, c1);
      @(posedge clk); #2;
      chk("abort_wr_pre", {31'b0, mem_write_read}, 32'd1);
      rsp0 = resp_cnt;
      reset = 1'b1;
      #1;
      chk("abort_wr_drop", {31'b0, mem_write_read}, 32'd0);
      @(negedge clk);
      @(negedge clk); #1;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("abort_no_resp", resp_cnt - rsp0, 32'd0);
      chk("abort_ready", {31'b0, req_ready}, 32'd1);
      chk("mem4_after_abort", mem[4], 32'hA5AD8001);

      // held req_valid: store then load to the same address
      send(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b1, c1);
      send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, c2);
      chk("b2b_gap", c2 - c1, 32'd3);
      wait_resp(rd, er, lat);
      chk("b2b_lat", lat, 32'd2);
      chk("b2b_err", {31'b0, er}, 32'd0);
      chk("b2b_rdata", rd, 32'h12345678);
      chk("mem8", mem[8], 32'h12345678);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
